// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Consumer side of the program-counter interface. Samples pc_in, fetches the
//   instruction word over a req/ack memory handshake, and hands it (with its
//   address) to the decoder over a valid/ready handshake. Pulses inc_pc when
//   the decoder accepts a word. A flush drops the current or in-flight
//   instruction; a memory timeout parks the unit in a sticky error state.
//
// Ports
//   clk         in   clock, rising edge
//   rstn        in   asynchronous reset, active HIGH (1 = reset)
//   enable      in   permits starting a new fetch from IDLE
//   flush       in   PC reload this cycle; drop current/in-flight instruction
//   pc_in       in   current program counter
//   inc_pc      out  advance PC at this edge (combinational)
//   imem_req    out  memory read request
//   imem_addr   out  memory read address, stable while imem_req=1
//   imem_ack    in   memory response pulse
//   imem_rdata  in   memory read data, valid with imem_ack
//   ir_valid    out  ir_out/ir_pc hold a valid instruction
//   ir_ready    in   decoder ready
//   ir_out      out  instruction register
//   ir_pc       out  address the instruction was fetched from
//   fetch_err   out  sticky memory-timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               inc_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               fetch_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DISCARD,
    VALID,
    ERR
  } state_e;

  state_e             state_q, state_d;
  logic               imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic               ir_valid_q, ir_valid_d;
  logic [INSTR_W-1:0] ir_out_q, ir_out_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0]   tmo_cnt_inc;

  assign tmo_cnt_inc = tmo_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    ir_valid_d  = ir_valid_q;
    ir_out_d    = ir_out_q;
    ir_pc_d     = ir_pc_q;
    fetch_err_d = fetch_err_q;
    tmo_cnt_d   = tmo_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (enable && !flush) begin
          state_d     = REQ;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_in;
          tmo_cnt_d   = '0;
        end
      end
      REQ: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          if (!flush) begin
            state_d    = VALID;
            ir_out_d   = imem_rdata;
            ir_pc_d    = imem_addr_q;
            ir_valid_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_cnt_inc == TMO_LAST) begin
          // Timeout takes priority over a simultaneous flush.
          state_d     = ERR;
          imem_req_d  = 1'b0;
          fetch_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_inc;
          // Request cannot be withdrawn; wait out the ack and drop it.
          if (flush) state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = IDLE;
        end else if (tmo_cnt_inc == TMO_LAST) begin
          state_d     = ERR;
          imem_req_d  = 1'b0;
          fetch_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_inc;
        end
      end
      VALID: begin
        // Either a handshake or a flush retires the word; only the
        // handshake (without flush) advances the PC via inc_pc.
        if (flush || ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      ERR: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      ir_valid_q  <= 1'b0;
      ir_out_q    <= '0;
      ir_pc_q     <= '0;
      fetch_err_q <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      ir_valid_q  <= ir_valid_d;
      ir_out_q    <= ir_out_d;
      ir_pc_q     <= ir_pc_d;
      fetch_err_q <= fetch_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign inc_pc    = ir_valid_q & ir_ready & ~flush;
  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign ir_valid  = ir_valid_q;
  assign ir_out    = ir_out_q;
  assign ir_pc     = ir_pc_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit with TIMEOUT_CYC=8. The bench plays
//   the program counter (pc_in advances on sampled inc_pc) and the memory
//   (imem_ack driven per step). Accepted words are pushed to a scoreboard at
//   ack time and popped when the decoder handshake completes.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rstn;
  logic               enable;
  logic               flush;
  logic [ADDR_W-1:0]  pc_in;
  logic               inc_pc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               ir_valid;
  logic               ir_ready;
  logic [INSTR_W-1:0] ir_out;
  logic [ADDR_W-1:0]  ir_pc;
  logic               fetch_err;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   inc_count = 0;

  instr_fetch_unit #(
    .ADDR_W     (ADDR_W),
    .INSTR_W    (INSTR_W),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .flush     (flush),
    .pc_in     (pc_in),
    .inc_pc    (inc_pc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .ir_out    (ir_out),
    .ir_pc     (ir_pc),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshake/inc_pc mid-cycle, then advance to 1 time unit
  // past the rising edge and act as the program counter.
  task automatic step();
    logic inc;
    exp_t e;
    @(negedge clk);
    inc = inc_pc;
    if (ir_valid && ir_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_handshake", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ir_out", 64'(ir_out), 64'(e.word));
        chk("sb_ir_pc", 64'(ir_pc), 64'(e.pc));
      end
    end else if (ir_valid && flush && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (inc) begin
      inc_count++;
      pc_in = pc_in + 1'b1;
    end
  endtask

  initial begin
    rstn = 1'b1; enable = 1'b0; flush = 1'b0; pc_in = '0;
    imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
    step(); step();
    rstn = 1'b0;
    step();
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_ir_valid", 64'(ir_valid), 64'd0);
    chk("rst_ir_out", 64'(ir_out), 64'd0);
    chk("rst_ir_pc", 64'(ir_pc), 64'd0);
    chk("rst_fetch_err", 64'(fetch_err), 64'd0);
    chk("rst_inc_pc", 64'(inc_pc), 64'd0);

    // T2: basic fetch, ack two cycles after request
    pc_in = 16'h0010; enable = 1'b1; ir_ready = 1'b1;
    step();
    chk("t2_req", 64'(imem_req), 64'd1);
    chk("t2_addr", 64'(imem_addr), 64'h10);
    step();
    chk("t2_addr_stable", 64'(imem_addr), 64'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    exp_q.push_back('{pc: 16'h0010, word: 32'hDEADBEEF});
    step();
    imem_ack = 1'b0;
    chk("t2_ir_valid", 64'(ir_valid), 64'd1);
    chk("t2_ir_out", 64'(ir_out), 64'hDEADBEEF);
    chk("t2_ir_pc", 64'(ir_pc), 64'h10);
    chk("t2_req_low", 64'(imem_req), 64'd0);
    chk("t2_inc_pc", 64'(inc_pc), 64'd1);
    step();
    chk("t2_inc_once", 64'(inc_count), 64'd1);
    chk("t2_inc_pulse_end", 64'(inc_pc), 64'd0);
    chk("t2_valid_drop", 64'(ir_valid), 64'd0);
    step();
    chk("t2_next_req", 64'(imem_req), 64'd1);
    chk("t2_next_addr", 64'(imem_addr), 64'h11);

    // T3: backpressure for 5 cycles
    ir_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
    exp_q.push_back('{pc: 16'h0011, word: 32'hCAFEF00D});
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid_held", 64'(ir_valid), 64'd1);
      chk("t3_out_held", 64'(ir_out), 64'hCAFEF00D);
      chk("t3_no_inc", 64'(inc_pc), 64'd0);
      step();
    end
    ir_ready = 1'b1; enable = 1'b0;
    #1;
    chk("t3_inc_on_ready", 64'(inc_pc), 64'd1);
    step();
    chk("t3_inc_count", 64'(inc_count), 64'd2);
    chk("t3_valid_drop", 64'(ir_valid), 64'd0);
    step();
    chk("t3_idle_disabled", 64'(imem_req), 64'd0);

    // T4: flush while the fetch is in flight
    enable = 1'b1;
    step();
    chk("t4_addr", 64'(imem_addr), 64'h12);
    flush = 1'b1; pc_in = 16'h0040;
    step();
    flush = 1'b0;
    chk("t4_req_held", 64'(imem_req), 64'd1);
    chk("t4_addr_held", 64'(imem_addr), 64'h12);
    step(); step();
    imem_ack = 1'b1; imem_rdata = 32'h12345678;
    step();
    imem_ack = 1'b0;
    chk("t4_req_drop", 64'(imem_req), 64'd0);
    chk("t4_no_valid", 64'(ir_valid), 64'd0);
    chk("t4_data_hidden", 64'(ir_out == 32'h12345678), 64'd0);
    step();
    chk("t4_refetch_addr", 64'(imem_addr), 64'h40);
    chk("t4_refetch_req", 64'(imem_req), 64'd1);
    chk("t4_inc_count", 64'(inc_count), 64'd2);

    // T5: flush and ready together in VALID
    imem_ack = 1'b1; imem_rdata = 32'hA5A50040;
    exp_q.push_back('{pc: 16'h0040, word: 32'hA5A50040});
    step();
    imem_ack = 1'b0;
    flush = 1'b1; ir_ready = 1'b1; pc_in = 16'h0080;
    #1;
    chk("t5_valid", 64'(ir_valid), 64'd1);
    chk("t5_no_inc", 64'(inc_pc), 64'd0);
    step();
    flush = 1'b0;
    chk("t5_valid_drop", 64'(ir_valid), 64'd0);
    chk("t5_inc_count", 64'(inc_count), 64'd2);
    step();
    chk("t5_refetch_addr", 64'(imem_addr), 64'h80);
    imem_ack = 1'b1; imem_rdata = 32'h0BADC0DE;
    exp_q.push_back('{pc: 16'h0080, word: 32'h0BADC0DE});
    step();
    imem_ack = 1'b0;
    step();
    chk("t5_inc_count2", 64'(inc_count), 64'd3);

    // T6: timeout with TIMEOUT_CYC=8 (request held 7 cycles)
    step();
    chk("t6_addr", 64'(imem_addr), 64'h81);
    for (int i = 0; i < 7; i++) begin
      chk("t6_req_hold", 64'(imem_req), 64'd1);
      chk("t6_no_err", 64'(fetch_err), 64'd0);
      step();
    end
    chk("t6_req_drop", 64'(imem_req), 64'd0);
    chk("t6_err", 64'(fetch_err), 64'd1);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF0000;
    step();
    imem_ack = 1'b0;
    step(); step();
    chk("t6_err_sticky", 64'(fetch_err), 64'd1);
    chk("t6_ack_ignored", 64'(ir_valid), 64'd0);
    chk("t6_req_stays_low", 64'(imem_req), 64'd0);

    // T1: asynchronous reset, first out of ERR then mid-REQ
    rstn = 1'b1;
    #1;
    chk("t1_err_cleared", 64'(fetch_err), 64'd0);
    step();
    rstn = 1'b0;
    step();
    chk("t1_new_req", 64'(imem_req), 64'd1);
    #2;
    rstn = 1'b1;
    #1;
    chk("t1_async_req", 64'(imem_req), 64'd0);
    chk("t1_async_valid", 64'(ir_valid), 64'd0);
    chk("t1_async_err", 64'(fetch_err), 64'd0);
    enable = 1'b0;
    step();
    rstn = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h55AA55AA;
    step();
    imem_ack = 1'b0;
    step();
    chk("t1_idle_req", 64'(imem_req), 64'd0);
    chk("t1_idle_valid", 64'(ir_valid), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
